keypad_scanner: RTL

- Parametrised matrix-keypad scanner for the PmodKYPD family and larger matrices.
- Drives one active-low column at a time and samples synchronised rows after a settle delay.
- Classifies each full scan frame as none, one or multiple keys, debounces across frames, and emits press/release events through a one-entry valid/ready buffer.
- Sits between the keypad pins and any consumer: seven-segment driver, FIFO or UART.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_col_timer.sv | 54 +++++
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad scanner: debounce FSM states, per-frame
// classification and the Digilent 4x4 legend lookup.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_PEND,
        ST_HELD,
        ST_REL_PEND
    } deb_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_ONE,
        FR_MULTI
    } frame_res_e;

    // Index is r*4+c; rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    function automatic logic [3:0] hex4x4(input logic [3:0] idx);
        logic [3:0] hex;
        case (idx)
            4'd0:    hex = 4'h1;
            4'd1:    hex = 4'h2;
            4'd2:    hex = 4'h3;
            4'd3:    hex = 4'hA;
            4'd4:    hex = 4'h4;
            4'd5:    hex = 4'h5;
            4'd6:    hex = 4'h6;
            4'd7:    hex = 4'hB;
            4'd8:    hex = 4'h7;
            4'd9:    hex = 4'h8;
            4'd10:   hex = 4'h9;
            4'd11:   hex = 4'hC;
            4'd12:   hex = 4'h0;
            4'd13:   hex = 4'hF;
            4'd14:   hex = 4'hE;
            default: hex = 4'hD;
        endcase
        return hex;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event stream: one-entry valid/ready channel from scanner to consumer.
interface keypad_scanner_if #(parameter int IW = 4);
    logic          evt_valid;
    logic          evt_ready;
    logic          evt_release;
    logic [IW-1:0] evt_index;
    logic [3:0]    evt_hex;

    modport master (output evt_valid, evt_release, evt_index, evt_hex, input evt_ready);
    modport slave  (input evt_valid, evt_release, evt_index, evt_hex, output evt_ready);
endinterface

// File: rtl/keypad_col_timer.sv
// Column scan timing: slot counter, rotating active-low column drive,
// row-sample strobe and end-of-frame strobe.
module keypad_col_timer #(
    parameter int NUM_COLS      = 4,
    parameter int COL_CYCLES    = 100000,
    parameter int SETTLE_CYCLES = 8,
    localparam int CW = $clog2(NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] col_o,
    output logic [CW-1:0]       col_idx_o,
    output logic                sample_o,
    output logic                frame_end_o
);
    localparam int SW = $clog2(COL_CYCLES);

    logic [SW-1:0]       slot_q, slot_d;
    logic [CW-1:0]       col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_q, col_d, col_drive;

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_drive
        assign col_drive[NUM_COLS-1-gi] = (col_idx_q != CW'(gi));
    end

    always_comb begin
        slot_d    = slot_q + SW'(1);
        col_idx_d = col_idx_q;
        if (slot_q == SW'(COL_CYCLES - 1)) begin
            slot_d    = '0;
            col_idx_d = (col_idx_q == CW'(NUM_COLS - 1)) ? '0 : col_idx_q + CW'(1);
        end
        // Drive is registered, so the new column appears one cycle after slot 0.
        col_d = (slot_q == '0) ? col_drive : col_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= '0;
            col_idx_q <= '0;
            col_q     <= '1;
        end else begin
            slot_q    <= slot_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
        end
    end

    assign col_o       = col_q;
    assign col_idx_o   = col_idx_q;
    assign sample_o    = (slot_q == SW'(SETTLE_CYCLES));
    assign frame_end_o = sample_o && (col_idx_q == CW'(NUM_COLS - 1));

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: synchronises rows, classifies each scan frame,
// debounces across frames and queues press/release events.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int COL_CYCLES      = 100000,
    parameter int SETTLE_CYCLES   = 8,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    keypad_scanner_if.master    evt,
    output logic                key_held,
    output logic                multi_key,
    output logic                overrun
);
    localparam int IW = $clog2(NUM_ROWS * NUM_COLS);
    localparam int CW = $clog2(NUM_COLS);
    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

    logic [CW-1:0] col_idx;
    logic          sample, frame_end;

    keypad_col_timer #(
        .NUM_COLS      (NUM_COLS),
        .COL_CYCLES    (COL_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .col_o       (col),
        .col_idx_o   (col_idx),
        .sample_o    (sample),
        .frame_end_o (frame_end)
    );

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [1:0]          acc_cnt_q, col_cnt, tot_cnt;
    logic [2:0]          sum_cnt;
    logic [IW-1:0]       acc_idx_q, col_hit_idx, frame_idx;
    frame_res_e          frame_res;
    logic                multi_key_q;

    always_comb begin
        col_cnt     = '0;
        col_hit_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_sync_q[NUM_ROWS-1-r]) begin
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
                col_hit_idx = IW'(r * NUM_COLS + int'(col_idx));
            end
        end
        sum_cnt   = {1'b0, acc_cnt_q} + {1'b0, col_cnt};
        tot_cnt   = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        frame_idx = (col_cnt != 2'd0) ? col_hit_idx : acc_idx_q;
        case (tot_cnt)
            2'd0:    frame_res = FR_NONE;
            2'd1:    frame_res = FR_ONE;
            default: frame_res = FR_MULTI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            acc_cnt_q   <= '0;
            acc_idx_q   <= '0;
            multi_key_q <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            if (frame_end) begin
                acc_cnt_q   <= '0;
                acc_idx_q   <= '0;
                multi_key_q <= (tot_cnt == 2'd2);
            end else if (sample) begin
                acc_cnt_q <= tot_cnt;
                acc_idx_q <= frame_idx;
            end
        end
    end

    deb_state_e    state_q, state_d;
    logic [IW-1:0] cand_q, cand_d;
    logic [3:0]    deb_cnt_q, deb_cnt_d, deb_inc;
    logic          push, push_rel;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        push      = 1'b0;
        push_rel  = 1'b0;
        deb_inc   = deb_cnt_q + 4'd1;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: if (frame_res == FR_ONE) begin
                    cand_d = frame_idx;
                    if (DEBOUNCE_FRAMES == 1) begin
                        state_d = ST_HELD;
                        push    = 1'b1;
                    end else begin
                        state_d   = ST_PRESS_PEND;
                        deb_cnt_d = 4'd1;
                    end
                end
                ST_PRESS_PEND: begin
                    if (frame_res != FR_ONE) begin
                        state_d = ST_IDLE;
                    end else if (frame_idx != cand_q) begin
                        cand_d    = frame_idx;
                        deb_cnt_d = 4'd1;
                    end else begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DF) begin
                            state_d = ST_HELD;
                            push    = 1'b1;
                        end
                    end
                end
                // Rollover keys while held are ignored; only a clear frame starts release.
                ST_HELD: if (frame_res == FR_NONE) begin
                    deb_cnt_d = 4'd1;
                    if (DEBOUNCE_FRAMES == 1) begin
                        state_d  = ST_IDLE;
                        push     = 1'b1;
                        push_rel = 1'b1;
                    end else begin
                        state_d = ST_REL_PEND;
                    end
                end
                default: begin
                    if (frame_res != FR_NONE) begin
                        state_d = ST_HELD;
                    end else begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DF) begin
                            state_d  = ST_IDLE;
                            push     = 1'b1;
                            push_rel = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    logic          evt_valid_q, evt_release_q, overrun_q;
    logic [IW-1:0] evt_index_q;
    logic [3:0]    evt_hex_q, push_hex;

    assign push_hex = (NUM_ROWS == 4 && NUM_COLS == 4) ? hex4x4(4'(cand_d)) : 4'h0;

    // A full, undrained buffer keeps its old event and flags the new one as lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_q   <= 1'b0;
            evt_release_q <= 1'b0;
            evt_index_q   <= '0;
            evt_hex_q     <= '0;
            overrun_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (push && (!evt_valid_q || evt.evt_ready)) begin
                evt_valid_q   <= 1'b1;
                evt_release_q <= push_rel;
                evt_index_q   <= cand_d;
                evt_hex_q     <= push_hex;
            end else if (push) begin
                overrun_q <= 1'b1;
            end else if (evt_valid_q && evt.evt_ready) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid   = evt_valid_q;
    assign evt.evt_release = evt_release_q;
    assign evt.evt_index   = evt_index_q;
    assign evt.evt_hex     = evt_hex_q;
    assign key_held        = (state_q == ST_HELD) || (state_q == ST_REL_PEND);
    assign multi_key       = multi_key_q;
    assign overrun         = overrun_q;

endmodule
